coder_4_2_drain_encoder: RTL and testbench
==========================================

Name: coder_4_2_drain_encoder

Overview:
- Inverse of the team's 2-to-4 index decoder: accepts a 4-bit request vector and emits, one beat per handshake, the 2-bit index of every set bit in priority order.
- Lets a one-hot or multi-hot select vector be turned back into an index stream for downstream index-driven logic.
- Valid/ready on both sides; the vector is buffered internally and drained bit by bit.

Parameters:
- WIDTH, 4, request vector width; fixed at 4 for this block.
- IDX_W, 2, index width; equals log2(WIDTH).
- LSB_FIRST, 1, 1 = lowest set bit has priority; 0 = highest set bit has priority.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream vector available.
- in_ready  output  1  block can accept a vector this cycle.
- in_vector  input  WIDTH  request vector; sampled when in_valid and in_ready are both 1.
- out_valid  output  1  out_index, out_last and out_empty are valid.
- out_ready  input  1  downstream accepts the current beat.
- out_index  output  IDX_W  index of the currently selected set bit.
- out_last  output  1  current beat is the final beat for this vector.
- out_empty  output  1  the accepted vector was all zeros (no-hit beat).

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; pend register=0.
  - Outputs after reset: in_ready=1, out_valid=0, out_index=0, out_last=0, out_empty=0.
  - Reset mid-drain discards the remaining bits; no further beats are emitted.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - DRAIN: in_ready=0, out_valid=1.
- IDLE -> DRAIN on input handshake.
  - pend <= in_vector.
  - First beat is valid on the next cycle (1-cycle latency: accept at cycle N, out_valid=1 at N+1).
- DRAIN outputs, all registered; no combinational path from in_* to out_*:
  - out_index = priority select of pend.
    - LSB_FIRST=1: lowest set bit.
    - LSB_FIRST=0: highest set bit.
  - out_last = 1 when pend has exactly one bit set, or pend==0.
  - out_empty = 1 only when pend==0.
- Output handshake (out_valid & out_ready):
  - Clear the selected bit in pend.
  - If out_last=1, return to IDLE; out_valid=0 the next cycle.
  - Otherwise stay in DRAIN and present the next index the next cycle.
- out_ready=0: the beat holds. out_index, out_last and out_empty stay stable until accepted.
- Zero vector: exactly one beat with out_index=0, out_empty=1, out_last=1.
- Beat count per vector = popcount(in_vector), or 1 if the vector is zero. Throughput is 1 beat/cycle when out_ready=1.
- in_ready is 0 for the whole drain, including the last-beat cycle.
  - Minimum turnaround: one IDLE cycle between vectors.
  - A vector offered during DRAIN is not sampled; upstream must hold it.
- All-ones vector with LSB_FIRST=1: indices 0,1,2,3; last asserted on index 3.
- Index width: out_index is exactly IDX_W bits; no wrap-around is possible since WIDTH=4.

Decomposition:
- Shared package coder_pkg:
  - Constants: CODER_WIDTH=4, CODER_IDX_W=2.
  - State enum: IDLE=1'b0, DRAIN=1'b1.
  - Shared with the 2-to-4 decoder so both ends agree on widths.
- One sub-module, coder_4_2_priority:
  - Combinational find-first-set over WIDTH bits, parameter LSB_FIRST.
  - Outputs: index, any_set, one_hot_sel.
  - The top clears the pend bit with pend & ~one_hot_sel.
  - Instantiated once; keeps the FSM file focused on the handshake logic.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then 0 -> in_ready=1, out_valid=0, out_index=0 and out_empty=0 every cycle until a vector is sent.
- Single bit: LSB_FIRST=1, in_vector=4'b0100 accepted at cycle N, out_ready=1 -> at N+1 out_index=2, out_last=1; out_valid=0 at N+2; in_ready=1 at N+2.
- Multi-hot with stall: in_vector=4'b1011, out_ready low for 2 cycles on the first beat -> index 0 holds stable, then indices 0,1,3 with out_last only on 3; exactly 3 beats.
- Priority direction: LSB_FIRST=0, in_vector=4'b1111 -> indices 3,2,1,0; out_last on 0.
- Zero vector: in_vector=4'b0000 -> one beat with out_index=0, out_empty=1, out_last=1; then in_ready=1.
- Reset mid-drain: in_vector=4'b1110, assert rst after the first accepted beat (index 1) -> next cycle out_valid=0, in_ready=1; index 2 and 3 never appear; a new vector 4'b0001 then yields a single beat with index 0.

Source files
------------

// File: rtl/coder_pkg.sv
// Shared widths and FSM state encoding for the 2<->4 index coder pair.
// Both the decoder and the drain encoder import this package so they agree on widths.
package coder_pkg;

  localparam int CODER_WIDTH = 4;
  localparam int CODER_IDX_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

endpackage

// File: rtl/coder_4_2_priority.sv
// Combinational find-first-set over WIDTH bits.
// LSB_FIRST selects whether the lowest or the highest set bit wins.
module coder_4_2_priority
  import coder_pkg::*;
#(
  parameter int WIDTH     = CODER_WIDTH,
  parameter int IDX_W     = CODER_IDX_W,
  parameter int LSB_FIRST = 1
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] index,
  output logic             any_set,
  output logic [WIDTH-1:0] one_hot_sel
);

  logic        found;
  int unsigned b;

  always_comb begin
    index       = '0;
    one_hot_sel = '0;
    found       = 1'b0;
    b           = 0;
    any_set     = |vec;
    // Scan in priority order; the first hit is latched through 'found'.
    for (int k = 0; k < WIDTH; k++) begin
      b = (LSB_FIRST != 0) ? k : (WIDTH - 1 - k);
      if (!found && vec[b]) begin
        found          = 1'b1;
        index          = IDX_W'(b);
        one_hot_sel[b] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/coder_4_2_drain_encoder.sv
// Buffers a request vector and emits the index of each set bit, one beat per
// output handshake, in priority order. A zero vector yields a single empty beat.
module coder_4_2_drain_encoder
  import coder_pkg::*;
#(
  parameter int WIDTH     = CODER_WIDTH,
  parameter int IDX_W     = CODER_IDX_W,
  parameter int LSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vector,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic             out_last,
  output logic             out_empty
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pend_q, pend_d;

  logic [IDX_W-1:0] sel_index;
  logic             sel_any;
  logic [WIDTH-1:0] sel_one_hot;
  logic [WIDTH-1:0] pend_rest;

  coder_4_2_priority #(
    .WIDTH    (WIDTH),
    .IDX_W    (IDX_W),
    .LSB_FIRST(LSB_FIRST)
  ) u_prio (
    .vec        (pend_q),
    .index      (sel_index),
    .any_set    (sel_any),
    .one_hot_sel(sel_one_hot)
  );

  // Bits still pending once the current beat is taken; zero means this is the last beat.
  assign pend_rest = pend_q & ~sel_one_hot;

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DRAIN);
    out_index = out_valid ? sel_index : '0;
    out_last  = out_valid && (pend_rest == '0);
    out_empty = out_valid && !sel_any;
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = DRAIN;
          pend_d  = in_vector;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          pend_d = pend_rest;
          if (out_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

endmodule

// File: tb/tb_coder_4_2_drain_encoder.sv
// Directed bench for the drain encoder: one LSB-first and one MSB-first instance.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_coder_4_2_drain_encoder;

  logic       clk = 1'b0;
  logic       rst;

  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last, a_out_empty;
  logic [3:0] a_in_vector;
  logic [1:0] a_out_index;

  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_out_empty;
  logic [3:0] b_in_vector;
  logic [1:0] b_out_index;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  coder_4_2_drain_encoder #(.LSB_FIRST(1)) dut_a (
    .clk      (clk),
    .rst      (rst),
    .in_valid (a_in_valid),
    .in_ready (a_in_ready),
    .in_vector(a_in_vector),
    .out_valid(a_out_valid),
    .out_ready(a_out_ready),
    .out_index(a_out_index),
    .out_last (a_out_last),
    .out_empty(a_out_empty)
  );

  coder_4_2_drain_encoder #(.LSB_FIRST(0)) dut_b (
    .clk      (clk),
    .rst      (rst),
    .in_valid (b_in_valid),
    .in_ready (b_in_ready),
    .in_vector(b_in_vector),
    .out_valid(b_out_valid),
    .out_ready(b_out_ready),
    .out_index(b_out_index),
    .out_last (b_out_last),
    .out_empty(b_out_empty)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full beat check on instance A.
  task automatic chk_a(input string tag, input logic v, input logic [1:0] idx,
                       input logic last, input logic empty);
    chk({tag, ".valid"}, 32'(a_out_valid), 32'(v));
    chk({tag, ".index"}, 32'(a_out_index), 32'(idx));
    chk({tag, ".last"},  32'(a_out_last),  32'(last));
    chk({tag, ".empty"}, 32'(a_out_empty), 32'(empty));
  endtask

  initial begin
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_vector = '0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_vector = '0; b_out_ready = 1'b0;

    // Reset then idle
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rst.in_ready", 32'(a_in_ready), 32'd1);
      chk_a("rst", 1'b0, 2'd0, 1'b0, 1'b0);
      chk("rst.b_valid", 32'(b_out_valid), 32'd0);
      step();
    end

    // Single bit 0100
    a_in_valid = 1'b1; a_in_vector = 4'b0100; a_out_ready = 1'b1;
    step();
    a_in_valid = 1'b0;
    chk_a("single", 1'b1, 2'd2, 1'b1, 1'b0);
    chk("single.in_ready", 32'(a_in_ready), 32'd0);
    step();
    chk("single.done_valid", 32'(a_out_valid), 32'd0);
    chk("single.done_ready", 32'(a_in_ready), 32'd1);

    // Multi-hot 1011 with a 2-cycle stall on the first beat
    a_in_valid = 1'b1; a_in_vector = 4'b1011; a_out_ready = 1'b0;
    step();
    a_in_valid = 1'b0; a_in_vector = 4'b0100;  // must not be sampled during drain
    chk_a("mh.b0", 1'b1, 2'd0, 1'b0, 1'b0);
    step();
    chk_a("mh.hold1", 1'b1, 2'd0, 1'b0, 1'b0);
    step();
    chk_a("mh.hold2", 1'b1, 2'd0, 1'b0, 1'b0);
    a_out_ready = 1'b1;
    step();
    chk_a("mh.b1", 1'b1, 2'd1, 1'b0, 1'b0);
    chk("mh.in_ready", 32'(a_in_ready), 32'd0);
    step();
    chk_a("mh.b3", 1'b1, 2'd3, 1'b1, 1'b0);
    chk("mh.last_in_ready", 32'(a_in_ready), 32'd0);
    step();
    chk_a("mh.done", 1'b0, 2'd0, 1'b0, 1'b0);
    chk("mh.done_ready", 32'(a_in_ready), 32'd1);

    // MSB-first priority on 1111
    b_in_valid = 1'b1; b_in_vector = 4'b1111; b_out_ready = 1'b1;
    step();
    b_in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("msb.valid", 32'(b_out_valid), 32'd1);
      chk("msb.index", 32'(b_out_index), 32'(3 - k));
      chk("msb.last",  32'(b_out_last),  32'(k == 3));
      step();
    end
    chk("msb.done", 32'(b_out_valid), 32'd0);

    // Zero vector
    a_in_valid = 1'b1; a_in_vector = 4'b0000; a_out_ready = 1'b1;
    step();
    a_in_valid = 1'b0;
    chk_a("zero", 1'b1, 2'd0, 1'b1, 1'b1);
    step();
    chk_a("zero.done", 1'b0, 2'd0, 1'b0, 1'b0);
    chk("zero.in_ready", 32'(a_in_ready), 32'd1);

    // Reset mid-drain on 1110
    a_in_valid = 1'b1; a_in_vector = 4'b1110; a_out_ready = 1'b1;
    step();
    a_in_valid = 1'b0;
    chk_a("mid.b1", 1'b1, 2'd1, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("mid.valid", 32'(a_out_valid), 32'd0);
      chk("mid.in_ready", 32'(a_in_ready), 32'd1);
      step();
    end
    a_in_valid = 1'b1; a_in_vector = 4'b0001;
    step();
    a_in_valid = 1'b0;
    chk_a("post", 1'b1, 2'd0, 1'b1, 1'b0);
    step();
    chk("post.done", 32'(a_out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
